// File: rtl/multi_chan_gated_counter_pkg.sv
// -----------------------------------------------------------------------------
// mcgc_pkg
// Shared constants and helpers for the multi-channel gated counter.
//   MCGC_CHANNELS   : default number of channels
//   MCGC_WIDTH      : default per-channel count width
//   MCGC_MODULUS    : default count sequence length (0..MODULUS-1)
//   MCGC_STOP_DELAY : default stop-echo delay in cycles
//   mcgc_params_ok(): legality check used at elaboration by the top level
// -----------------------------------------------------------------------------
package mcgc_pkg;

  localparam int MCGC_CHANNELS   = 4;
  localparam int MCGC_WIDTH      = 4;
  localparam int MCGC_MODULUS    = 14;
  localparam int MCGC_STOP_DELAY = 2;

  // Legal ranges: CHANNELS 1..16, WIDTH 2..16, MODULUS 2..2**WIDTH,
  // STOP_DELAY 1..8.
  function automatic bit mcgc_params_ok(input int channels, input int width,
                                        input int modulus, input int stop_delay);
    bit ok;
    ok = 1'b1;
    if (channels < 1 || channels > 16) ok = 1'b0;
    if (width < 2 || width > 16) ok = 1'b0;
    if (modulus < 2) ok = 1'b0;
    if (width >= 2 && width <= 16 && modulus > (1 << width)) ok = 1'b0;
    if (stop_delay < 1 || stop_delay > 8) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/multi_chan_gated_counter_if.sv
// -----------------------------------------------------------------------------
// multi_chan_gated_counter_if
// Bundles the per-channel control and status vectors of the counter.
//   start    [CHANNELS]        : run request, level sampled every rising edge
//   stop     [CHANNELS]        : halt request, level sampled every rising edge
//   count    [CHANNELS*WIDTH]  : channel n count at [n*WIDTH +: WIDTH]
//   running  [CHANNELS]        : registered per-channel enable
//   wrap     [CHANNELS]        : one-cycle pulse when count returns to 0
//   stop_dly [CHANNELS]        : stop echoed STOP_DELAY cycles later
//   load / load_val            : only present when MCGC_LOAD_EN is defined
// Modports: master = stimulus side, slave = counter side.
//
// Signalling: there is no valid/ready handshake. Every input is a level that
// the counter samples on each rising clk edge; a request held for N edges is
// seen N times. All outputs are registered and change only on clk or reset.
// -----------------------------------------------------------------------------
interface multi_chan_gated_counter_if
  import mcgc_pkg::*;
#(
  parameter int CHANNELS = MCGC_CHANNELS,
  parameter int WIDTH    = MCGC_WIDTH
) ();

  logic [CHANNELS-1:0]       start;
  logic [CHANNELS-1:0]       stop;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       running;
  logic [CHANNELS-1:0]       wrap;
  logic [CHANNELS-1:0]       stop_dly;
`ifdef MCGC_LOAD_EN
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] load_val;
`endif

`ifdef MCGC_LOAD_EN
  modport master (output start, stop, load, load_val,
                  input  count, running, wrap, stop_dly);
  modport slave  (input  start, stop, load, load_val,
                  output count, running, wrap, stop_dly);
`else
  modport master (output start, stop,
                  input  count, running, wrap, stop_dly);
  modport slave  (input  start, stop,
                  output count, running, wrap, stop_dly);
`endif

endinterface

// File: rtl/multi_chan_gated_counter_channel.sv
// -----------------------------------------------------------------------------
// mcgc_channel
// One counter channel: enable flop, modulo counter with wrap pulse, and a
// STOP_DELAY-stage shift register echoing stop.
// Optional feature macro: MCGC_LOAD_EN (adds i_load / i_load_val).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_start      : run request (wins over i_stop)
//   i_stop       : halt request
//   i_load       : (MCGC_LOAD_EN) load i_load_val into the counter
//   i_load_val   : (MCGC_LOAD_EN) value to load; values >= MODULUS load 0
//   o_count      : current count, always < MODULUS
//   o_running    : registered enable (also the channel's visible state)
//   o_wrap       : high for the cycle the count shows 0 after MODULUS-1
//   o_stop_dly   : i_stop delayed by STOP_DELAY cycles
// -----------------------------------------------------------------------------
module mcgc_channel
  import mcgc_pkg::*;
#(
  parameter int WIDTH      = MCGC_WIDTH,
  parameter int MODULUS    = MCGC_MODULUS,
  parameter int STOP_DELAY = MCGC_STOP_DELAY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
`ifdef MCGC_LOAD_EN
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
`endif
  output logic [WIDTH-1:0] o_count,
  output logic             o_running,
  output logic             o_wrap,
  output logic             o_stop_dly
);

  localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MODULUS - 1);

  logic                  r_running;
  logic [WIDTH-1:0]      r_count;
  logic                  r_wrap;
  logic [STOP_DELAY-1:0] r_stop_sr;

  logic                  w_running_nxt;
  logic [WIDTH-1:0]      w_count_nxt;
  logic                  w_wrap_nxt;

  // Enable: start has priority, stop clears, otherwise hold.
  always_comb begin
    w_running_nxt = r_running;
    if (i_start) begin
      w_running_nxt = 1'b1;
    end else if (i_stop) begin
      w_running_nxt = 1'b0;
    end
  end

  // Counter: the increment uses the enable as it was before the edge, so the
  // first increment lands one cycle after start is sampled. At MODULUS-1 the
  // counter loads 0 explicitly, which also covers MODULUS == 2**WIDTH.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (r_running) begin
      if (r_count == LP_LAST) begin
        w_count_nxt = '0;
        w_wrap_nxt  = 1'b1;
      end else begin
        w_count_nxt = r_count + WIDTH'(1);
      end
    end
`ifdef MCGC_LOAD_EN
    // Load overrides increment and wrap; out-of-range values clamp to 0 so
    // the count never leaves 0..MODULUS-1.
    if (i_load) begin
      w_wrap_nxt = 1'b0;
      if ({1'b0, i_load_val} > {1'b0, LP_LAST}) begin
        w_count_nxt = '0;
      end else begin
        w_count_nxt = i_load_val;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_running <= 1'b0;
      r_count   <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_running <= w_running_nxt;
      r_count   <= w_count_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

  // Stage 0 captures stop; the last stage is the echo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stop_sr <= '0;
    end else begin
      r_stop_sr[0] <= i_stop;
      for (int i = 1; i < STOP_DELAY; i++) begin
        r_stop_sr[i] <= r_stop_sr[i-1];
      end
    end
  end

  assign o_count    = r_count;
  assign o_running  = r_running;
  assign o_wrap     = r_wrap;
  assign o_stop_dly = r_stop_sr[STOP_DELAY-1];

endmodule

// File: rtl/multi_chan_gated_counter.sv
// -----------------------------------------------------------------------------
// multi_chan_gated_counter
// CHANNELS independent start/stop-gated modulo counters, each with a wrap
// pulse and a delayed stop echo.
// Optional feature macro: MCGC_LOAD_EN (per-channel synchronous load).
// Parameters: CHANNELS (1..16), WIDTH (2..16), MODULUS (2..2**WIDTH),
//             STOP_DELAY (1..8); illegal values stop elaboration.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : multi_chan_gated_counter_if.slave carrying start, stop, count,
//           running, wrap, stop_dly (and load, load_val with MCGC_LOAD_EN)
// -----------------------------------------------------------------------------
module multi_chan_gated_counter
  import mcgc_pkg::*;
#(
  parameter int CHANNELS   = MCGC_CHANNELS,
  parameter int WIDTH      = MCGC_WIDTH,
  parameter int MODULUS    = MCGC_MODULUS,
  parameter int STOP_DELAY = MCGC_STOP_DELAY
) (
  input logic                        clk,
  input logic                        reset,
  multi_chan_gated_counter_if.slave  bus
);

  if (!mcgc_params_ok(CHANNELS, WIDTH, MODULUS, STOP_DELAY)) begin : g_bad_params
    $fatal(1, "multi_chan_gated_counter: illegal parameter set");
  end

  logic [CHANNELS*WIDTH-1:0] w_count;
  logic [CHANNELS-1:0]       w_running;
  logic [CHANNELS-1:0]       w_wrap;
  logic [CHANNELS-1:0]       w_stop_dly;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    mcgc_channel #(
      .WIDTH      (WIDTH),
      .MODULUS    (MODULUS),
      .STOP_DELAY (STOP_DELAY)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .i_start    (bus.start[g]),
      .i_stop     (bus.stop[g]),
`ifdef MCGC_LOAD_EN
      .i_load     (bus.load[g]),
      .i_load_val (bus.load_val[g*WIDTH +: WIDTH]),
`endif
      .o_count    (w_count[g*WIDTH +: WIDTH]),
      .o_running  (w_running[g]),
      .o_wrap     (w_wrap[g]),
      .o_stop_dly (w_stop_dly[g])
    );
  end

  assign bus.count    = w_count;
  assign bus.running  = w_running;
  assign bus.wrap     = w_wrap;
  assign bus.stop_dly = w_stop_dly;

endmodule

// File: tb/tb_multi_chan_gated_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_chan_gated_counter
// Directed bench. dut_a: 4 channels, WIDTH 4, MODULUS 14, STOP_DELAY 3.
// dut_b: 1 channel, WIDTH 3, MODULUS 8 (natural rollover), STOP_DELAY 1.
// Inputs change just after a falling edge; outputs are checked on falling
// edges, so each check sees the result of the rising edge before it.
// -----------------------------------------------------------------------------
module tb_multi_chan_gated_counter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  multi_chan_gated_counter_if #(.CHANNELS(4), .WIDTH(4)) if_a ();
  multi_chan_gated_counter_if #(.CHANNELS(1), .WIDTH(3)) if_b ();

  multi_chan_gated_counter #(
    .CHANNELS(4), .WIDTH(4), .MODULUS(14), .STOP_DELAY(3)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  multi_chan_gated_counter #(
    .CHANNELS(1), .WIDTH(3), .MODULUS(8), .STOP_DELAY(1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] cnt_a(input int n);
    return if_a.count[n*4 +: 4];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset        = 1'b1;
    if_a.start   = 4'hF;   // must be ignored while reset is high
    if_a.stop    = 4'h0;
    if_b.start   = 1'b1;
    if_b.stop    = 1'b0;
`ifdef MCGC_LOAD_EN
    if_a.load     = '0;
    if_a.load_val = '0;
    if_b.load     = '0;
    if_b.load_val = '0;
`endif
    repeat (3) @(negedge clk);
    n_vec++; if (if_a.count !== 16'h0) begin n_err++; $display("FAIL rst_count: got %h want 0000", if_a.count); end
    n_vec++; if (if_a.running !== 4'h0) begin n_err++; $display("FAIL rst_running: got %b want 0000", if_a.running); end
    n_vec++; if (if_a.wrap !== 4'h0) begin n_err++; $display("FAIL rst_wrap: got %b want 0000", if_a.wrap); end
    n_vec++; if (if_a.stop_dly !== 4'h0) begin n_err++; $display("FAIL rst_stop_dly: got %b want 0000", if_a.stop_dly); end
    n_vec++; if (if_b.running !== 1'b0 || if_b.count !== 3'd0) begin n_err++; $display("FAIL rst_b: got run=%b cnt=%0d want 0/0", if_b.running, if_b.count); end
    if_a.start = 4'h0;
    if_b.start = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    n_vec++; if (if_a.running !== 4'h0) begin n_err++; $display("FAIL post_rst_running: got %b want 0000", if_a.running); end
    n_vec++; if (if_a.count !== 16'h0) begin n_err++; $display("FAIL post_rst_count: got %h want 0000", if_a.count); end
  endtask

  task automatic test_count_wrap();
    if_a.start[0] = 1'b1;
    @(negedge clk);
    if_a.start[0] = 1'b0;
    n_vec++; if (if_a.running[0] !== 1'b1 || cnt_a(0) !== 4'd0) begin n_err++; $display("FAIL ch0_start: got run=%b cnt=%0d want 1/0", if_a.running[0], cnt_a(0)); end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      n_vec++; if (cnt_a(0) !== 4'(k) || if_a.wrap[0] !== 1'b0) begin n_err++; $display("FAIL ch0_count k=%0d: got cnt=%0d wrap=%b want %0d/0", k, cnt_a(0), if_a.wrap[0], k); end
    end
    @(negedge clk);
    n_vec++; if (cnt_a(0) !== 4'd0 || if_a.wrap[0] !== 1'b1) begin n_err++; $display("FAIL ch0_wrap: got cnt=%0d wrap=%b want 0/1", cnt_a(0), if_a.wrap[0]); end
    @(negedge clk);
    n_vec++; if (cnt_a(0) !== 4'd1 || if_a.wrap[0] !== 1'b0) begin n_err++; $display("FAIL ch0_after_wrap: got cnt=%0d wrap=%b want 1/0", cnt_a(0), if_a.wrap[0]); end
    if_a.stop[0] = 1'b1;
    @(negedge clk);
    if_a.stop[0] = 1'b0;
    n_vec++; if (cnt_a(0) !== 4'd2 || if_a.running[0] !== 1'b0) begin n_err++; $display("FAIL ch0_stop: got cnt=%0d run=%b want 2/0", cnt_a(0), if_a.running[0]); end
    @(negedge clk);
    n_vec++; if (cnt_a(0) !== 4'd2) begin n_err++; $display("FAIL ch0_hold: got %0d want 2", cnt_a(0)); end
  endtask

  task automatic test_start_stop_same();
    if_a.start[1] = 1'b1;
    if_a.stop[1]  = 1'b1;
    @(negedge clk);
    if_a.start[1] = 1'b0;
    if_a.stop[1]  = 1'b0;
    n_vec++; if (if_a.running[1] !== 1'b1 || cnt_a(1) !== 4'd0) begin n_err++; $display("FAIL ch1_priority: got run=%b cnt=%0d want 1/0", if_a.running[1], cnt_a(1)); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_vec++; if (cnt_a(1) !== 4'(k)) begin n_err++; $display("FAIL ch1_count k=%0d: got %0d want %0d", k, cnt_a(1), k); end
    end
    // stop sampled while count shows 4: the final increment lands on 5
    if_a.stop[1] = 1'b1;
    @(negedge clk);
    if_a.stop[1] = 1'b0;
    n_vec++; if (cnt_a(1) !== 4'd5 || if_a.running[1] !== 1'b0) begin n_err++; $display("FAIL ch1_stop: got cnt=%0d run=%b want 5/0", cnt_a(1), if_a.running[1]); end
    @(negedge clk);
    n_vec++; if (cnt_a(1) !== 4'd5) begin n_err++; $display("FAIL ch1_hold: got %0d want 5", cnt_a(1)); end
    n_vec++; if (cnt_a(0) !== 4'd2) begin n_err++; $display("FAIL ch0_indep: got %0d want 2", cnt_a(0)); end
  endtask

  task automatic test_stop_delay();
    repeat (4) @(negedge clk);
    if_a.stop[2] = 1'b1;
    @(negedge clk);
    if_a.stop[2] = 1'b0;
    n_vec++; if (if_a.stop_dly[2] !== 1'b0) begin n_err++; $display("FAIL sd_d1: got %b want 0", if_a.stop_dly[2]); end
    @(negedge clk);
    n_vec++; if (if_a.stop_dly[2] !== 1'b0) begin n_err++; $display("FAIL sd_d2: got %b want 0", if_a.stop_dly[2]); end
    @(negedge clk);
    n_vec++; if (if_a.stop_dly !== 4'b0100) begin n_err++; $display("FAIL sd_d3: got %b want 0100", if_a.stop_dly); end
    @(negedge clk);
    n_vec++; if (if_a.stop_dly !== 4'b0000) begin n_err++; $display("FAIL sd_d4: got %b want 0000", if_a.stop_dly); end
    n_vec++; if (if_a.running[2] !== 1'b0 || cnt_a(2) !== 4'd0) begin n_err++; $display("FAIL ch2_idle: got run=%b cnt=%0d want 0/0", if_a.running[2], cnt_a(2)); end
  endtask

  task automatic test_back_to_back();
    // start and stop held together on ch3: start keeps winning every edge
    if_a.start[3] = 1'b1;
    if_a.stop[3]  = 1'b1;
    @(negedge clk);
    n_vec++; if (if_a.running[3] !== 1'b1 || cnt_a(3) !== 4'd0) begin n_err++; $display("FAIL ch3_b2b0: got run=%b cnt=%0d want 1/0", if_a.running[3], cnt_a(3)); end
    @(negedge clk);
    n_vec++; if (cnt_a(3) !== 4'd1) begin n_err++; $display("FAIL ch3_b2b1: got %0d want 1", cnt_a(3)); end
    @(negedge clk);
    if_a.start[3] = 1'b0;
    if_a.stop[3]  = 1'b0;
    n_vec++; if (cnt_a(3) !== 4'd2 || if_a.running[3] !== 1'b1) begin n_err++; $display("FAIL ch3_b2b2: got cnt=%0d run=%b want 2/1", cnt_a(3), if_a.running[3]); end
    @(negedge clk);
    n_vec++; if (cnt_a(3) !== 4'd3) begin n_err++; $display("FAIL ch3_b2b3: got %0d want 3", cnt_a(3)); end
  endtask

`ifdef MCGC_LOAD_EN
  task automatic test_load();
    if_a.load[3]            = 1'b1;
    if_a.load_val[12 +: 4]  = 4'd9;
    @(negedge clk);
    if_a.load[3] = 1'b0;
    n_vec++; if (cnt_a(3) !== 4'd9 || if_a.running[3] !== 1'b1) begin n_err++; $display("FAIL ld9: got cnt=%0d run=%b want 9/1", cnt_a(3), if_a.running[3]); end
    @(negedge clk);
    n_vec++; if (cnt_a(3) !== 4'd10) begin n_err++; $display("FAIL ld9_inc: got %0d want 10", cnt_a(3)); end
    if_a.load[3]           = 1'b1;
    if_a.load_val[12 +: 4] = 4'd15;
    @(negedge clk);
    if_a.load[3] = 1'b0;
    n_vec++; if (cnt_a(3) !== 4'd0 || if_a.wrap[3] !== 1'b0) begin n_err++; $display("FAIL ld15: got cnt=%0d wrap=%b want 0/0", cnt_a(3), if_a.wrap[3]); end
    @(negedge clk);
    n_vec++; if (cnt_a(3) !== 4'd1) begin n_err++; $display("FAIL ld15_inc: got %0d want 1", cnt_a(3)); end
  endtask
`endif

  task automatic test_async_reset();
    if_a.start[0] = 1'b1;
    @(negedge clk);
    if_a.start[0] = 1'b0;
    n_vec++; if (if_a.running[0] !== 1'b1 || cnt_a(0) !== 4'd2) begin n_err++; $display("FAIL ch0_resume: got run=%b cnt=%0d want 1/2", if_a.running[0], cnt_a(0)); end
    repeat (3) @(negedge clk);     // count 5
    if_a.stop[3] = 1'b1;           // leave a stop in the delay line
    @(negedge clk);
    if_a.stop[3] = 1'b0;
    @(negedge clk);
    n_vec++; if (cnt_a(0) !== 4'd7) begin n_err++; $display("FAIL ch0_pre_rst: got %0d want 7", cnt_a(0)); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (if_a.count !== 16'h0) begin n_err++; $display("FAIL arst_count: got %h want 0000", if_a.count); end
    n_vec++; if (if_a.running !== 4'h0) begin n_err++; $display("FAIL arst_running: got %b want 0000", if_a.running); end
    n_vec++; if (if_a.stop_dly !== 4'h0 || if_a.wrap !== 4'h0) begin n_err++; $display("FAIL arst_sd_wrap: got sd=%b wrap=%b want 0/0", if_a.stop_dly, if_a.wrap); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if (if_a.stop_dly !== 4'h0 || if_a.running !== 4'h0 || if_a.count !== 16'h0) begin n_err++; $display("FAIL post_arst k=%0d: got sd=%b run=%b cnt=%h want 0", k, if_a.stop_dly, if_a.running, if_a.count); end
    end
  endtask

  task automatic test_small_width();
    if_b.start = 1'b1;
    @(negedge clk);
    if_b.start = 1'b0;
    n_vec++; if (if_b.running !== 1'b1 || if_b.count !== 3'd0) begin n_err++; $display("FAIL b_start: got run=%b cnt=%0d want 1/0", if_b.running, if_b.count); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_vec++; if (if_b.count !== 3'(k) || if_b.wrap !== 1'b0) begin n_err++; $display("FAIL b_count k=%0d: got cnt=%0d wrap=%b want %0d/0", k, if_b.count, if_b.wrap, k); end
    end
    @(negedge clk);
    n_vec++; if (if_b.count !== 3'd0 || if_b.wrap !== 1'b1) begin n_err++; $display("FAIL b_wrap: got cnt=%0d wrap=%b want 0/1", if_b.count, if_b.wrap); end
    if_b.stop = 1'b1;
    @(negedge clk);
    if_b.stop = 1'b0;
    n_vec++; if (if_b.count !== 3'd1 || if_b.wrap !== 1'b0 || if_b.running !== 1'b0) begin n_err++; $display("FAIL b_stop: got cnt=%0d wrap=%b run=%b want 1/0/0", if_b.count, if_b.wrap, if_b.running); end
    n_vec++; if (if_b.stop_dly !== 1'b1) begin n_err++; $display("FAIL b_sd1: got %b want 1", if_b.stop_dly); end
    @(negedge clk);
    n_vec++; if (if_b.stop_dly !== 1'b0 || if_b.count !== 3'd1) begin n_err++; $display("FAIL b_sd_off: got sd=%b cnt=%0d want 0/1", if_b.stop_dly, if_b.count); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_count_wrap();
    test_start_stop_same();
    test_stop_delay();
    test_back_to_back();
`ifdef MCGC_LOAD_EN
    test_load();
`endif
    test_async_reset();
    test_small_width();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
